hazard_unit_scb: RTL and testbench
==================================

Name: hazard_unit_scb

Overview:
- Parametrised successor to the pipelined core's combinational hazard unit. Sits between the control path and the data path.
- Keeps existing behaviour: M/W forwarding, load-use stall, branch flush.
- Adds a register scoreboard for variable-latency long operations (divider, multi-cycle memory) that complete out of band. Stall conditions cover RAW, WAW and scoreboard-full.
- Adds saturating stall and flush performance counters.

Parameters:
REG_AW, 5, register address width; scoreboard has 2**REG_AW pending bits
MAX_PENDING, 4, maximum outstanding long operations
CNT_W, 32, performance counter width

Ports:
i_Clk  in  1  clock, rising edge
i_Reset_n  in  1  asynchronous, active-low reset
i_Rs1D, i_Rs2D, i_RdD  in  REG_AW  decode-stage source and destination registers
i_LongOpD  in  1  decode instruction is a long operation
i_Rs1E, i_Rs2E, i_RdE  in  REG_AW  execute-stage registers
i_ResultSrcE_0  in  1  execute instruction is a load
i_LongIssueE  in  1  long operation in E, issues this cycle with destination i_RdE
i_PCSrcE  in  1  taken branch or jump resolved in E
i_RdM, i_RdW  in  REG_AW  M and W destinations
i_RegWriteM, i_RegWriteW  in  1  M and W register-write enables
i_LongDone  in  1  a long operation's result is in W this cycle
i_LongDoneRd  in  REG_AW  destination of the completing long operation
i_CntClr  in  1  synchronous clear of the performance counters
o_StallF, o_StallD, o_FlushD, o_FlushE  out  1  pipeline controls
o_ForwardAE, o_ForwardBE  out  2  operand select: 00 register file, 01 W, 10 M
o_ScbFull  out  1  outstanding count == MAX_PENDING
o_ScbErr  out  1  sticky: completion seen for a non-pending register
o_StallCount, o_FlushCount  out  CNT_W  performance counters

Behaviour:
- Forwarding (combinational), A operand:
  - 10 if i_RegWriteM && i_RdM!=0 && i_RdM==i_Rs1E;
  - else 01 if i_RegWriteW && i_RdW!=0 && i_RdW==i_Rs1E;
  - else 00.
  - B operand identical using i_Rs2E. M has priority over W.
- LoadStall = i_ResultSrcE_0 && i_RdE!=0 && (i_RdE==i_Rs1D || i_RdE==i_Rs2D).
- ScbStall is asserted when any of these holds:
  - pending[i_Rs1D] or pending[i_Rs2D] (RAW); bit 0 is never set;
  - i_RdD!=0 && pending[i_RdD] (WAW);
  - i_LongIssueE && i_RdE!=0 && i_RdE matches i_Rs1D or i_Rs2D (pending bit not yet set);
  - i_LongOpD && count==MAX_PENDING.
- Pipeline controls:
  - o_StallF = o_StallD = (LoadStall | ScbStall) & ~i_PCSrcE. The D instruction is killed by a taken branch, so the stall is masked.
  - o_FlushD = i_PCSrcE.
  - o_FlushE = LoadStall | ScbStall | i_PCSrcE.
- Scoreboard update (registered, rising edge):
  - Issue: if i_LongIssueE && i_RdE!=0, set pending[i_RdE] and increment count.
  - Complete: if i_LongDone && pending[i_LongDoneRd], clear the bit and decrement count.
  - Issue and complete in the same cycle: both applied, count unchanged. WAW stall guarantees they target different registers.
  - Completion to a non-pending register: ignored, count unchanged, o_ScbErr set (sticky until reset).
  - Issue at count==MAX_PENDING cannot occur (full stall); if it does, count saturates and o_ScbErr is set.
- Consumer timing: a consumer stalled in D is released the cycle after i_LongDone. Pending clears at the end of the completion cycle, and the register file is written during W.
- Counters:
  - o_StallCount += 1 every cycle o_StallD=1; saturates at all-ones.
  - o_FlushCount += 1 every cycle i_PCSrcE=1; saturates at all-ones.
  - i_CntClr zeroes both next edge; clear has priority over increment.
- Reset (i_Reset_n=0, asynchronous):
  - pending=0, count=0, o_ScbErr=0, both counters 0.
  - With idle inputs, all combinational outputs are 0.
  - Reset mid-operation drops all outstanding entries. Long-unit completions arriving after release are treated as errors (o_ScbErr). The long unit must share the reset.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Same with RegWriteM=0 -> ForwardAE=01.
- Load-use: ResultSrcE_0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Same with PCSrcE=1 -> StallD=0, FlushD=FlushE=1.
- Scoreboard RAW: issue x9 long, then D reads x9 -> stalls every cycle until LongDone/LongDoneRd=9. StallD drops the next cycle; StallCount equals stalled cycles.
- Full: with MAX_PENDING=4, issue to x1..x4, LongOpD=1 -> ScbFull=1, StallD=1. Done x2 with simultaneous issue to x6 -> count stays 4.
- Error/reset: LongDone for x12 never issued -> ScbErr=1, count unchanged. Reset asserted mid-run with 3 pending -> all cleared asynchronously, ScbErr=0.
- Counter saturation: CNT_W=4, hold PCSrcE=1 for 20 cycles -> FlushCount=15. CntClr=1 -> 0 next edge.

Source files
------------

// File: rtl/hazard_unit_scb.sv
// Hazard unit with long-operation scoreboard.
// Resolves M/W operand forwarding, load-use stalls and branch flushes for the
// five-stage core, and tracks destinations of variable-latency long operations
// (divider, multi-cycle memory) so that RAW/WAW consumers are held in D until
// the result reaches W. Saturating stall/flush counters expose pipeline health.
module hazard_unit_scb #(
    parameter int REG_AW      = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 32
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic [REG_AW-1:0] i_Rs1D,
    input  logic [REG_AW-1:0] i_Rs2D,
    input  logic [REG_AW-1:0] i_RdD,
    input  logic              i_LongOpD,
    input  logic [REG_AW-1:0] i_Rs1E,
    input  logic [REG_AW-1:0] i_Rs2E,
    input  logic [REG_AW-1:0] i_RdE,
    input  logic              i_ResultSrcE_0,
    input  logic              i_LongIssueE,
    input  logic              i_PCSrcE,
    input  logic [REG_AW-1:0] i_RdM,
    input  logic [REG_AW-1:0] i_RdW,
    input  logic              i_RegWriteM,
    input  logic              i_RegWriteW,
    input  logic              i_LongDone,
    input  logic [REG_AW-1:0] i_LongDoneRd,
    input  logic              i_CntClr,
    output logic              o_StallF,
    output logic              o_StallD,
    output logic              o_FlushD,
    output logic              o_FlushE,
    output logic [1:0]        o_ForwardAE,
    output logic [1:0]        o_ForwardBE,
    output logic              o_ScbFull,
    output logic              o_ScbErr,
    output logic [CNT_W-1:0]  o_StallCount,
    output logic [CNT_W-1:0]  o_FlushCount
);

    localparam int NREG = 2**REG_AW;
    localparam int CW   = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_PENDING);

    logic [NREG-1:0]  r_pending;
    logic [CW-1:0]    r_count;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [NREG-1:0]  w_pending_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_err_set;
    logic             w_issue;
    logic             w_done_hit;
    logic             w_done_miss;
    logic             w_full;
    logic             w_raw;
    logic             w_waw;
    logic             w_issue_byp;
    logic             w_full_stall;
    logic             w_load_stall;
    logic             w_scb_stall;
    logic             w_stall;

    // Operand forwarding: the younger result in M wins over W; x0 never forwards.
    always_comb begin
        o_ForwardAE = 2'b00;
        o_ForwardBE = 2'b00;
        if (i_RegWriteM && (i_RdM != '0) && (i_RdM == i_Rs1E))
            o_ForwardAE = 2'b10;
        else if (i_RegWriteW && (i_RdW != '0) && (i_RdW == i_Rs1E))
            o_ForwardAE = 2'b01;
        if (i_RegWriteM && (i_RdM != '0) && (i_RdM == i_Rs2E))
            o_ForwardBE = 2'b10;
        else if (i_RegWriteW && (i_RdW != '0) && (i_RdW == i_Rs2E))
            o_ForwardBE = 2'b01;
    end

    // Stall sources: load-use, scoreboard hazards (including the issue cycle,
    // when the pending bit is not yet visible) and a full scoreboard.
    always_comb begin
        w_load_stall = i_ResultSrcE_0 && (i_RdE != '0) &&
                       ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
        w_raw        = r_pending[i_Rs1D] | r_pending[i_Rs2D];
        w_waw        = (i_RdD != '0) && r_pending[i_RdD];
        w_issue_byp  = i_LongIssueE && (i_RdE != '0) &&
                       ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
        w_full       = (r_count == C_MAX);
        w_full_stall = i_LongOpD && w_full;
        w_scb_stall  = w_raw | w_waw | w_issue_byp | w_full_stall;
        w_stall      = w_load_stall | w_scb_stall;
    end

    // Pipeline controls. A taken branch kills the D instruction, so holding it is pointless.
    always_comb begin
        o_StallF  = w_stall & ~i_PCSrcE;
        o_StallD  = w_stall & ~i_PCSrcE;
        o_FlushD  = i_PCSrcE;
        o_FlushE  = w_stall | i_PCSrcE;
        o_ScbFull = w_full;
        o_ScbErr  = r_err;
    end

    // Scoreboard next state: clear on completion, then set on issue.
    always_comb begin
        w_issue       = i_LongIssueE && (i_RdE != '0);
        w_done_hit    = i_LongDone && r_pending[i_LongDoneRd];
        w_done_miss   = i_LongDone && !r_pending[i_LongDoneRd];
        w_pending_nxt = r_pending;
        w_count_nxt   = r_count;
        if (w_done_hit)
            w_pending_nxt[i_LongDoneRd] = 1'b0;
        if (w_issue)
            w_pending_nxt[i_RdE] = 1'b1;
        unique case ({w_issue, w_done_hit})
            2'b10:   if (!w_full) w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        // Orphan completions and overflowing issues are protocol violations.
        w_err_set = w_done_miss | (w_issue & w_full & ~w_done_hit);
    end

    // Scoreboard state registers; the sticky error clears only on reset.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_pending <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
            r_err     <= r_err | w_err_set;
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_CntClr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_StallD && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (i_PCSrcE && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_StallCount = r_stall_cnt;
    assign o_FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit_scb.sv
// Directed bench for hazard_unit_scb: forwarding, load-use, scoreboard
// RAW/WAW/full, error and async reset, saturating counters (CNT_W=4).
module tb_hazard_unit_scb;

    localparam int REG_AW = 5;
    localparam int MAXP   = 4;
    localparam int CW     = 4;

    logic              i_Clk = 1'b0;
    logic              i_Reset_n;
    logic [REG_AW-1:0] i_Rs1D, i_Rs2D, i_RdD, i_Rs1E, i_Rs2E, i_RdE;
    logic [REG_AW-1:0] i_RdM, i_RdW, i_LongDoneRd;
    logic              i_LongOpD, i_ResultSrcE_0, i_LongIssueE, i_PCSrcE;
    logic              i_RegWriteM, i_RegWriteW, i_LongDone, i_CntClr;
    logic              o_StallF, o_StallD, o_FlushD, o_FlushE, o_ScbFull, o_ScbErr;
    logic [1:0]        o_ForwardAE, o_ForwardBE;
    logic [CW-1:0]     o_StallCount, o_FlushCount;

    int n_vec = 0;
    int n_err = 0;

    hazard_unit_scb #(.REG_AW(REG_AW), .MAX_PENDING(MAXP), .CNT_W(CW)) dut (
        .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
        .i_Rs1D(i_Rs1D), .i_Rs2D(i_Rs2D), .i_RdD(i_RdD), .i_LongOpD(i_LongOpD),
        .i_Rs1E(i_Rs1E), .i_Rs2E(i_Rs2E), .i_RdE(i_RdE),
        .i_ResultSrcE_0(i_ResultSrcE_0), .i_LongIssueE(i_LongIssueE), .i_PCSrcE(i_PCSrcE),
        .i_RdM(i_RdM), .i_RdW(i_RdW), .i_RegWriteM(i_RegWriteM), .i_RegWriteW(i_RegWriteW),
        .i_LongDone(i_LongDone), .i_LongDoneRd(i_LongDoneRd), .i_CntClr(i_CntClr),
        .o_StallF(o_StallF), .o_StallD(o_StallD), .o_FlushD(o_FlushD), .o_FlushE(o_FlushE),
        .o_ForwardAE(o_ForwardAE), .o_ForwardBE(o_ForwardBE),
        .o_ScbFull(o_ScbFull), .o_ScbErr(o_ScbErr),
        .o_StallCount(o_StallCount), .o_FlushCount(o_FlushCount)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle();
        i_Rs1D = '0; i_Rs2D = '0; i_RdD = '0; i_LongOpD = 1'b0;
        i_Rs1E = '0; i_Rs2E = '0; i_RdE = '0;
        i_ResultSrcE_0 = 1'b0; i_LongIssueE = 1'b0; i_PCSrcE = 1'b0;
        i_RdM = '0; i_RdW = '0; i_RegWriteM = 1'b0; i_RegWriteW = 1'b0;
        i_LongDone = 1'b0; i_LongDoneRd = '0; i_CntClr = 1'b0;
    endtask

    initial begin
        idle();
        i_Reset_n = 1'b0;
        #12;
        // Reset state with idle inputs
        check("rst_stall", {o_StallF, o_StallD, o_FlushD, o_FlushE}, 0);
        check("rst_fwd", {o_ForwardAE, o_ForwardBE}, 0);
        check("rst_scb", {o_ScbFull, o_ScbErr}, 0);
        check("rst_cnt", {o_StallCount, o_FlushCount}, 0);
        i_Reset_n = 1'b1;
        tick();

        // Forwarding
        i_RdM = 5; i_RegWriteM = 1; i_RdW = 5; i_RegWriteW = 1; i_Rs1E = 5; i_Rs2E = 0;
        #1;
        check("fwdA_M", o_ForwardAE, 2'b10);
        check("fwdB_x0", o_ForwardBE, 2'b00);
        i_RegWriteM = 0;
        #1;
        check("fwdA_W", o_ForwardAE, 2'b01);
        i_RegWriteM = 1; i_Rs2E = 5; i_RdW = 6; i_Rs1E = 6;
        #1;
        check("fwdB_M", o_ForwardBE, 2'b10);
        check("fwdA_W2", o_ForwardAE, 2'b01);
        i_RdM = 0; i_RdW = 0; i_Rs1E = 0; i_Rs2E = 0;
        #1;
        check("fwd_x0", {o_ForwardAE, o_ForwardBE}, 0);
        idle();
        tick();

        // Load-use: one stall cycle, then the bubble in E releases it
        i_ResultSrcE_0 = 1; i_RdE = 7; i_Rs2D = 7;
        #1;
        check("lu_ctl", {o_StallF, o_StallD, o_FlushD, o_FlushE}, 4'b1101);
        tick();
        i_ResultSrcE_0 = 0; i_RdE = 0;
        #1;
        check("lu_release", {o_StallF, o_StallD, o_FlushE}, 0);
        check("lu_cnt", o_StallCount, 1);
        i_ResultSrcE_0 = 1; i_RdE = 7; i_PCSrcE = 1;
        #1;
        check("lu_br_ctl", {o_StallF, o_StallD, o_FlushD, o_FlushE}, 4'b0011);
        tick();
        idle();
        #1;
        check("lu_br_cnt", {o_StallCount, o_FlushCount}, 8'h11);
        i_CntClr = 1;
        tick();
        i_CntClr = 0;
        check("cnt_clr0", {o_StallCount, o_FlushCount}, 0);

        // Scoreboard RAW/WAW on x9
        i_LongIssueE = 1; i_RdE = 9; i_Rs1D = 9;
        #1;
        check("raw_issue", o_StallD, 1);
        tick();
        i_LongIssueE = 0; i_RdE = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("raw_hold", {o_StallD, o_FlushE}, 2'b11);
            tick();
        end
        i_Rs1D = 0; i_RdD = 9;
        #1;
        check("waw_hold", o_StallD, 1);
        tick();
        i_RdD = 0; i_Rs1D = 9; i_LongDone = 1; i_LongDoneRd = 9;
        #1;
        check("raw_done_cycle", o_StallD, 1);
        tick();
        i_LongDone = 0; i_LongDoneRd = 0;
        #1;
        check("raw_release", o_StallD, 0);
        check("raw_cnt", o_StallCount, 6);
        check("raw_err", o_ScbErr, 0);
        idle();
        i_CntClr = 1;
        tick();
        i_CntClr = 0;

        // Full: issue x1..x4
        for (int r = 1; r <= 4; r++) begin
            i_LongIssueE = 1; i_RdE = REG_AW'(r);
            #1;
            check("full_pre", o_ScbFull, 0);
            tick();
        end
        i_LongIssueE = 0; i_RdE = 0; i_LongOpD = 1;
        #1;
        check("full_flag", {o_ScbFull, o_StallD}, 2'b11);
        i_LongOpD = 0;
        #1;
        check("full_nostall", o_StallD, 0);
        i_LongDone = 1; i_LongDoneRd = 2; i_LongIssueE = 1; i_RdE = 6;
        tick();
        i_LongDone = 0; i_LongDoneRd = 0; i_LongIssueE = 0; i_RdE = 0;
        #1;
        check("full_swap", o_ScbFull, 1);
        i_Rs1D = 2;
        #1;
        check("x2_cleared", o_StallD, 0);
        i_Rs1D = 0; i_Rs2D = 6;
        #1;
        check("x6_pending", o_StallD, 1);
        i_Rs2D = 0;

        // Orphan completion
        i_LongDone = 1; i_LongDoneRd = 12;
        tick();
        i_LongDone = 0; i_LongDoneRd = 0;
        #1;
        check("orphan_err", {o_ScbFull, o_ScbErr}, 2'b11);
        i_LongDone = 1; i_LongDoneRd = 1;
        tick();
        i_LongDone = 0; i_LongDoneRd = 0;
        #1;
        check("three_pend", o_ScbFull, 0);

        // Async reset mid-cycle with x3, x4, x6 pending
        #2;
        i_Reset_n = 0; i_Rs1D = 3; i_Rs2D = 4; i_RdD = 6;
        #1;
        check("arst_err", o_ScbErr, 0);
        check("arst_pend", o_StallD, 0);
        #1;
        i_Reset_n = 1;
        idle();
        i_LongDone = 1; i_LongDoneRd = 3;
        tick();
        i_LongDone = 0; i_LongDoneRd = 0;
        #1;
        check("post_rst_orphan", o_ScbErr, 1);
        i_LongOpD = 1;
        for (int r = 1; r <= 3; r++) begin
            i_LongIssueE = 1; i_RdE = REG_AW'(r + 20);
            tick();
        end
        i_LongIssueE = 0; i_RdE = 0;
        #1;
        check("post_rst_cnt3", {o_ScbFull, o_StallD}, 0);
        idle();

        // Flush counter saturation
        i_CntClr = 1;
        tick();
        i_CntClr = 0;
        i_PCSrcE = 1;
        for (int i = 0; i < 20; i++) tick();
        check("flush_sat", o_FlushCount, 15);
        check("stall_zero", o_StallCount, 0);
        i_CntClr = 1;
        tick();
        check("clr_prio", o_FlushCount, 0);
        i_CntClr = 0;
        tick();
        check("flush_after_clr", o_FlushCount, 1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
